hamming_enc_fifo: RTL and testbench

//   Upstream producer for the Hamming correction stage. It accepts raw data words over a valid/ready handshake.

---
 rtl/hamming_pkg.sv | 49 ++++
 rtl/hamming_enc_word.sv | 49 ++++
 rtl/hamming_enc_fifo.sv | 90 +++++++++
 tb/tb_hamming_enc_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming layout used by the encoder and by the downstream decoder stage.
package hamming_pkg;

    localparam int MAX_DATA_W = 11;
    localparam int MAX_CODE_W = 15;

    // Parity bits sit at the power-of-two Hamming positions.
    localparam int PARITY_POS [4] = '{1, 2, 4, 8};

    // Hamming position of data slot j; slot 0 carries the data MSB.
    localparam int DATA_POS [MAX_DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    function automatic int code_w(input int data_w);
        return data_w + 4;
    endfunction

    // Position 1 is the code word MSB.
    function automatic int pos2idx(input int p, input int cw);
        return cw - p;
    endfunction

    function automatic bit is_parity_pos(input int p);
        bit r;
        r = 1'b0;
        for (int k = 0; k < 4; k++)
            if (PARITY_POS[k] == p) r = 1'b1;
        return r;
    endfunction

    // Data slot held at position p, or -1 for a parity position.
    function automatic int data_slot(input int p);
        int r;
        r = -1;
        for (int j = 0; j < MAX_DATA_W; j++)
            if (DATA_POS[j] == p) r = j;
        return r;
    endfunction

    // Bit p set when data position p feeds parity bit 2^k.
    function automatic logic [MAX_CODE_W:0] cover_mask(input int k);
        logic [MAX_CODE_W:0] m;
        m = '0;
        for (int p = 1; p <= MAX_CODE_W; p++)
            if (!is_parity_pos(p) && (((p >> k) & 1) != 0))
                m = m | ((MAX_CODE_W+1)'(1) << p);
        return m;
    endfunction

endpackage

// File: rtl/hamming_enc_word.sv
// Combinational Hamming encoder with optional single-position error injection.
module hamming_enc_word
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    localparam int CODE_W = code_w(DATA_W)
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        err_pos,
    output logic [CODE_W-1:0] code,
    output logic              inj
);

    // All vectors below are indexed by Hamming position, 1..CODE_W.
    logic [CODE_W:1] dpos;
    logic [CODE_W:1] enc;
    logic [CODE_W:1] fpos;
    logic [3:0]      par;

    // Out-of-range positions (0 or beyond the word) inject nothing.
    assign inj = (err_pos != 4'd0) && (err_pos <= 4'(CODE_W));

    for (genvar p = 1; p <= CODE_W; p++) begin : g_pos
        localparam int SLOT = data_slot(p);
        if (SLOT >= 0) begin : g_data
            assign dpos[p] = in_data[DATA_W-1-SLOT];
        end else begin : g_zero
            assign dpos[p] = 1'b0;
        end
    end

    // Even parity; when no data position has bit k set the mask is empty and parity is 0.
    for (genvar k = 0; k < 4; k++) begin : g_par
        localparam logic [MAX_CODE_W:0] MASK = cover_mask(k);
        assign par[k] = ^(dpos & MASK[CODE_W:1]);
    end

    for (genvar p = 1; p <= CODE_W; p++) begin : g_out
        localparam int IDX = pos2idx(p, CODE_W);
        if (is_parity_pos(p)) begin : g_p
            assign enc[p] = par[$clog2(p)];
        end else begin : g_d
            assign enc[p] = dpos[p];
        end
        assign fpos[p]   = enc[p] ^ (inj & (err_pos == 4'(p)));
        assign code[IDX] = fpos[p];
    end

endmodule

// File: rtl/hamming_enc_fifo.sv
// Hamming encoder front end feeding a DEPTH-entry FIFO toward the decoder stage.
module hamming_enc_fifo
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CODE_W = code_w(DATA_W),
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_err_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_inj,
    output logic [LVL_W-1:0]  level,
    output logic [15:0]       sent_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic              inj;
        logic [CODE_W-1:0] code;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            enc_entry;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    hamming_enc_word #(.DATA_W(DATA_W)) u_enc (
        .in_data (in_data),
        .err_pos (in_err_pos),
        .code    (enc_entry.code),
        .inj     (enc_entry.inj)
    );

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    // Full refuses pushes even if a pop happens on the same edge.
    assign push  = in_valid & ~full;
    assign pop   = out_ready & ~empty;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_code  = empty ? '0 : mem[rd_ptr].code;
    assign out_inj   = empty ? 1'b0 : mem[rd_ptr].inj;
    assign level     = level_q;

    // Storage needs no reset: entries are only visible while level covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_entry;
    end

    // Pointers wrap naturally (power-of-two depth); level tracks occupancy separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Popped-word counter, saturating rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sent_cnt <= '0;
        else if (pop && sent_cnt != 16'hFFFF)
            sent_cnt <= sent_cnt + 16'd1;
    end

endmodule

// File: tb/tb_hamming_enc_fifo.sv
// Scoreboard bench for hamming_enc_fifo with DATA_W=8, DEPTH=4.
module tb_hamming_enc_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [3:0]  in_err_pos = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_code;
    logic        out_inj;
    logic [2:0]  level;
    logic [15:0] sent_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] code;
        logic        inj;
        logic [7:0]  data;
    } exp_t;
    exp_t q[$];

    // Hand-computed code words.
    logic [7:0]  tv_d [7] = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'h3C};
    logic [11:0] tv_c [7] = '{12'hE45, 12'h000, 12'hEEF, 12'h111, 12'hE00, 12'h0AA, 12'h46C};

    hamming_enc_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_err_pos (in_err_pos),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_inj    (out_inj),
        .level      (level),
        .sent_cnt   (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int syndrome(input logic [11:0] c);
        int s;
        s = 0;
        for (int i = 1; i <= 12; i++)
            if (c[12-i]) s = s ^ i;
        return s;
    endfunction

    function automatic logic [7:0] decode(input logic [11:0] c);
        logic [12:1] p;
        int s;
        for (int i = 1; i <= 12; i++) p[i] = c[12-i];
        s = syndrome(c);
        if (s >= 1 && s <= 12) p[s] = ~p[s];
        return {p[3], p[5], p[6], p[7], p[9], p[10], p[11], p[12]};
    endfunction

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pop_code", 32'(out_code), 32'(e.code));
                    chk("pop_inj", 32'(out_inj), 32'(e.inj));
                    chk("pop_decode", 32'(decode(out_code)), 32'(e.data));
                    if (!e.inj) chk("pop_syndrome", syndrome(out_code), 0);
                end
            end else if (!out_valid) begin
                chk("empty_out", {out_code, 3'b0, out_inj}, 0);
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic push(input logic [7:0] d, input logic [3:0] e,
                        input logic [11:0] c, input logic inj, output logic acc);
        exp_t x;
        in_valid   = 1'b1;
        in_data    = d;
        in_err_pos = e;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        if (acc) begin
            x.code = c; x.inj = inj; x.data = d;
            q.push_back(x);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!out_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("drain_empty", 32'(out_valid), 0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic acc;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_sent", 32'(sent_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Basic encode, one-cycle latency
        push(8'hA5, 4'd0, 12'hE45, 1'b0, acc);
        @(negedge clk);
        chk("t1_code", 32'(out_code), 32'hE45);
        chk("t1_inj", 32'(out_inj), 0);
        chk("t1_level", 32'(level), 1);
        @(posedge clk); #1;
        drain();

        // Injected error at position 6
        push(8'hA5, 4'd6, 12'hE05, 1'b1, acc);
        @(negedge clk);
        chk("t2_code", 32'(out_code), 32'hE05);
        chk("t2_inj", 32'(out_inj), 1);
        @(posedge clk); #1;
        drain();

        // All-zero, all-one, out-of-range injection
        push(8'h00, 4'd0, 12'h000, 1'b0, acc);
        push(8'hFF, 4'd0, 12'hEEF, 1'b0, acc);
        push(8'hFF, 4'd13, 12'hEEF, 1'b0, acc);
        @(negedge clk);
        chk("t3_level", 32'(level), 3);
        @(posedge clk); #1;
        drain();

        // Fill to full, refuse 5th, refuse push during same-cycle pop
        for (int i = 0; i < 4; i++) push(tv_d[i], 4'd0, tv_c[i], 1'b0, acc);
        @(negedge clk);
        chk("t4_full_ready", 32'(in_ready), 0);
        chk("t4_full_level", 32'(level), 4);
        @(posedge clk); #1;
        push(8'h80, 4'd0, 12'hE00, 1'b0, acc);
        chk("t4_refuse5", 32'(acc), 0);
        out_ready = 1'b1;
        push(8'h5A, 4'd0, 12'h0AA, 1'b0, acc);
        chk("t4_refuse_on_pop", 32'(acc), 0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_level_after", 32'(level), 3);
        chk("t4_sent", 32'(sent_cnt), 6);

        // Asynchronous reset mid-burst
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_out_code", 32'(out_code), 0);
        chk("t6_level", 32'(level), 0);
        chk("t6_sent", 32'(sent_cnt), 0);
        do_reset();
        push(8'h3C, 4'd0, 12'h46C, 1'b0, acc);
        @(negedge clk);
        chk("t6_first_code", 32'(out_code), 32'h46C);
        chk("t6_first_level", 32'(level), 1);
        @(posedge clk); #1;
        drain();

        // Steady streaming, 100 words
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            exp_t x;
            in_valid   = 1'b1;
            in_data    = tv_d[i % 7];
            in_err_pos = 4'd0;
            @(negedge clk);
            if (i > 0) chk("t5_level", 32'(level), 1);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                x.code = tv_c[i % 7]; x.inj = 1'b0; x.data = tv_d[i % 7];
                q.push_back(x);
            end
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_last_level", 32'(level), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_drained", 32'(level), 0);
        chk("t5_sent", 32'(sent_cnt), 100);
        chk("t5_queue_empty", q.size(), 0);
        out_ready = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
